sine_pwm_sequencer: RTL

Drives the 8-bit PWM generator's duty input (D) and count enable (CE). Each PWM period is 256 CE ticks. At every period boundary the block advances a phase accumulator and loads the next duty from a quarter-wave sine table. The PWM output is therefore sine-modulated at a programmable rate. The block sits between the control/host logic (enable and step handshake) and the PWM generator in the SINE_WAVE design.

---
 rtl/sine_pwm_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sine_pwm_sequencer.sv
// sine_pwm_sequencer
// Feeds an 8-bit PWM generator with a sine-modulated duty value.
// A prescaler produces the count enable (CE). Every 256 CE ticks form one PWM period.
// At each period boundary a phase accumulator advances by the active step.
// The next duty is then looked up in a quarter-wave sine table.
//
// Optional feature macro: SINE_PWM_AMPL_EN
//   When defined, the block adds an AMPL[7:0] input.
//   The duty is then scaled around mid-scale: D = 128 + floor((sample-128)*AMPL/256).
//
// Ports:
//   CLK        system clock (rising edge)
//   RST        synchronous active-high reset
//   EN         run request (level)
//   STEP       phase increment per PWM period
//   STEP_LD    strobe capturing STEP into the pending step register
//   STEP_ACK   one-cycle acknowledge, the cycle after STEP_LD
//   AMPL       amplitude scale (only with SINE_PWM_AMPL_EN)
//   CE         count enable to the PWM generator
//   D          registered duty to the PWM generator
//   PERIOD_END pulse with the CE that ends a 256-tick period
//   BUSY       high whenever the sequencer is not idle
module sine_pwm_sequencer #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PHASE_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [PHASE_W-1:0] STEP,
    input  logic               STEP_LD,
`ifdef SINE_PWM_AMPL_EN
    input  logic [7:0]         AMPL,
`endif
    output logic               STEP_ACK,
    output logic               CE,
    output logic [7:0]         D,
    output logic               PERIOD_END,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    state_t             state_r;
    logic [15:0]        presc_r;
    logic [7:0]         tick_r;
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] step_active_r;
    logic [PHASE_W-1:0] step_pending_r;
    logic [7:0]         d_r;
    logic               ack_r;

    logic               ce_s;
    logic               pe_s;
    logic [PHASE_W-1:0] phase_next_s;
    logic [7:0]         duty_next_s;

    // T[k] = round(127*sin(pi*k/128)), k = 0..64
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] t;
        case (k)
            7'd0:  t = 7'd0;   7'd1:  t = 7'd3;   7'd2:  t = 7'd6;   7'd3:  t = 7'd9;
            7'd4:  t = 7'd12;  7'd5:  t = 7'd16;  7'd6:  t = 7'd19;  7'd7:  t = 7'd22;
            7'd8:  t = 7'd25;  7'd9:  t = 7'd28;  7'd10: t = 7'd31;  7'd11: t = 7'd34;
            7'd12: t = 7'd37;  7'd13: t = 7'd40;  7'd14: t = 7'd43;  7'd15: t = 7'd46;
            7'd16: t = 7'd49;  7'd17: t = 7'd51;  7'd18: t = 7'd54;  7'd19: t = 7'd57;
            7'd20: t = 7'd60;  7'd21: t = 7'd63;  7'd22: t = 7'd65;  7'd23: t = 7'd68;
            7'd24: t = 7'd71;  7'd25: t = 7'd73;  7'd26: t = 7'd76;  7'd27: t = 7'd78;
            7'd28: t = 7'd81;  7'd29: t = 7'd83;  7'd30: t = 7'd85;  7'd31: t = 7'd88;
            7'd32: t = 7'd90;  7'd33: t = 7'd92;  7'd34: t = 7'd94;  7'd35: t = 7'd96;
            7'd36: t = 7'd98;  7'd37: t = 7'd100; 7'd38: t = 7'd102; 7'd39: t = 7'd104;
            7'd40: t = 7'd106; 7'd41: t = 7'd107; 7'd42: t = 7'd109; 7'd43: t = 7'd111;
            7'd44: t = 7'd112; 7'd45: t = 7'd113; 7'd46: t = 7'd115; 7'd47: t = 7'd116;
            7'd48: t = 7'd117; 7'd49: t = 7'd118; 7'd50: t = 7'd120; 7'd51: t = 7'd121;
            7'd52: t = 7'd122; 7'd53: t = 7'd122; 7'd54: t = 7'd123; 7'd55: t = 7'd124;
            7'd56: t = 7'd125; 7'd57: t = 7'd125; 7'd58: t = 7'd126; 7'd59: t = 7'd126;
            7'd60: t = 7'd126; 7'd61: t = 7'd127; 7'd62: t = 7'd127; 7'd63: t = 7'd127;
            7'd64: t = 7'd127;
            default: t = 7'd0;
        endcase
        return t;
    endfunction

    // Odd quadrants mirror the table index; the upper half of the wave is negated around 128.
    function automatic logic [7:0] sine_sample(input logic [7:0] p);
        logic [6:0] idx;
        logic [6:0] t;
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        t   = quarter_sine(idx);
        return p[7] ? (8'd128 - {1'b0, t}) : (8'd128 + {1'b0, t});
    endfunction

`ifdef SINE_PWM_AMPL_EN
    // Scale the deviation from mid-scale; the arithmetic shift floors toward minus infinity.
    function automatic logic [7:0] scale_duty(input logic [7:0] s, input logic [7:0] a);
        logic signed [8:0]  dev;
        logic signed [17:0] prod;
        logic signed [17:0] res;
        dev  = $signed({1'b0, s}) - 9'sd128;
        prod = 18'(dev) * 18'($signed({1'b0, a}));
        res  = 18'sd128 + (prod >>> 8);
        return res[7:0];
    endfunction
`endif

    assign ce_s         = (state_r != IDLE) && (presc_r == PRE_LAST);
    assign pe_s         = ce_s && (tick_r == 8'hFF);
    assign phase_next_s = phase_r + step_active_r;

    assign CE         = ce_s;
    assign PERIOD_END = pe_s;
    assign BUSY       = (state_r != IDLE);
    assign D          = d_r;
    assign STEP_ACK   = ack_r;

    // Duty for the next period, taken from the advanced phase.
    always_comb begin
        duty_next_s = sine_sample(phase_next_s[PHASE_W-1 -: 8]);
`ifdef SINE_PWM_AMPL_EN
        duty_next_s = scale_duty(duty_next_s, AMPL);
`endif
    end

    // Sequencer FSM with prescaler, tick counter, phase accumulator and step handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= IDLE;
            presc_r        <= 16'd0;
            tick_r         <= 8'd0;
            phase_r        <= '0;
            step_active_r  <= '0;
            step_pending_r <= '0;
            d_r            <= 8'd0;
            ack_r          <= 1'b0;
        end else begin
            ack_r <= STEP_LD;
            if (STEP_LD) begin
                step_pending_r <= STEP;
            end
            case (state_r)
                IDLE: begin
                    step_active_r <= step_pending_r;
                    if (EN) begin
                        state_r <= RUN;
                        presc_r <= 16'd0;
                        tick_r  <= 8'd0;
                        phase_r <= '0;
                        d_r     <= 8'd128;
                    end
                end
                RUN, DRAIN: begin
                    presc_r <= (presc_r == PRE_LAST) ? 16'd0 : presc_r + 16'd1;
                    if (ce_s) begin
                        tick_r <= tick_r + 8'd1;
                    end
                    if (state_r == RUN) begin
                        // Boundary in RUN uses the old active step; a same-edge load waits one more period.
                        if (pe_s) begin
                            phase_r       <= phase_next_s;
                            d_r           <= duty_next_s;
                            step_active_r <= step_pending_r;
                        end
                        state_r <= EN ? RUN : DRAIN;
                    end else if (pe_s) begin
                        state_r <= IDLE;
                        d_r     <= 8'd0;
                    end else if (EN) begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    d_r     <= 8'd0;
                end
            endcase
        end
    end

endmodule
